// File: rtl/morse_pkg.sv
// Shared types for the Morse keyer: downstream symbol codes and keyer FSM states.
package morse_pkg;

  typedef enum logic [1:0] {
    DOT        = 2'd0,
    DASH       = 2'd1,
    LETTER_END = 2'd2,
    WORD_END   = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MARK      = 2'd1,
    ST_SPACE     = 2'd2,
    ST_WORD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/morse_unit_pulse.sv
// Morse unit prescaler: one-cycle unit_tick every UNIT_TICKS cycles after the last clear.
module morse_unit_pulse #(
  parameter int unsigned UNIT_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic unit_tick
);

  localparam int unsigned PW = $clog2(UNIT_TICKS);
  localparam logic [PW-1:0] LAST = PW'(UNIT_TICKS - 1);

  logic [PW-1:0] presc_r;

  // Prescaler counter: restarts on clear, wraps after LAST.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_r <= {PW{1'b0}};
    end else if (clear) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_r == LAST) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1'b1);
    end
  end

  // The tick is not masked by clear, so a wrap landing on an edge cycle still counts.
  assign unit_tick = (presc_r == LAST);

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer: times marks/spaces in units and emits DOT/DASH/LETTER_END/WORD_END symbols.
// Optional build macro MORSE_GLITCH_FILTER_EN drops marks shorter than GLITCH_TICKS cycles.
module morse_keyer_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS   = 1_000_000,
  parameter int unsigned DASH_UNITS   = 2,
  parameter int unsigned LETTER_UNITS = 2,
  parameter int unsigned WORD_UNITS   = 5,
  parameter int unsigned GLITCH_TICKS = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_i,
  output logic sym_valid_o,
  output sym_t sym_o,
  input  logic sym_ready_i,
  output logic overflow_o,
  output logic busy_o
);

  localparam int unsigned UW = $clog2(WORD_UNITS + 1);
  localparam logic [UW-1:0] DASH_U   = UW'(DASH_UNITS);
  localparam logic [UW-1:0] LETTER_U = UW'(LETTER_UNITS);
  localparam logic [UW-1:0] WORD_U   = UW'(WORD_UNITS);

  state_t        state_r, state_nxt_s, resume_s;
  logic          key_q_r, press_s, release_s, edge_s, unit_tick_s, glitch_s;
  logic [UW-1:0] unit_cnt_r, unit_eff_s;
  logic          emit_s, sym_valid_r, overflow_r, busy_r;
  sym_t          emit_sym_s, sym_r;

  assign press_s   = key_i & ~key_q_r;
  assign release_s = ~key_i & key_q_r;
  assign edge_s    = press_s | release_s;

  morse_unit_pulse #(.UNIT_TICKS(UNIT_TICKS)) u_unit_pulse (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (edge_s),
    .unit_tick (unit_tick_s)
  );

  // Unit count including a wrap that lands this cycle, saturating at WORD_UNITS.
  always_comb begin
    if (unit_tick_s && (unit_cnt_r != WORD_U)) begin
      unit_eff_s = unit_cnt_r + UW'(1'b1);
    end else begin
      unit_eff_s = unit_cnt_r;
    end
  end

`ifdef MORSE_GLITCH_FILTER_EN
  localparam int unsigned GW = $clog2(GLITCH_TICKS + 1);
  localparam logic [GW-1:0] GLITCH_N = GW'(GLITCH_TICKS);

  logic [GW-1:0] mark_len_r;
  state_t        pre_state_r;

  // Mark length in cycles (saturating) and the state to resume if the mark is a glitch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mark_len_r  <= {GW{1'b0}};
      pre_state_r <= ST_IDLE;
    end else if (press_s) begin
      mark_len_r  <= GW'(1'b1);
      pre_state_r <= state_r;
    end else if (mark_len_r != GLITCH_N) begin
      mark_len_r  <= mark_len_r + GW'(1'b1);
    end
  end

  assign glitch_s = (mark_len_r < GLITCH_N);
  assign resume_s = pre_state_r;
`else
  assign glitch_s = 1'b0;
  assign resume_s = ST_IDLE;
`endif

  // State, key history, unit counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      key_q_r    <= 1'b0;
      unit_cnt_r <= {UW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      key_q_r    <= key_i;
      unit_cnt_r <= edge_s ? {UW{1'b0}} : unit_eff_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic; a press always wins over a gap threshold reached the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_s) state_nxt_s = ST_MARK;
        else         state_nxt_s = ST_IDLE;
      end
      ST_MARK: begin
        if (release_s) state_nxt_s = glitch_s ? resume_s : ST_SPACE;
        else           state_nxt_s = ST_MARK;
      end
      ST_SPACE: begin
        if (press_s)                                     state_nxt_s = ST_MARK;
        else if (unit_tick_s && (unit_eff_s >= LETTER_U)) state_nxt_s = ST_WORD_WAIT;
        else                                             state_nxt_s = ST_SPACE;
      end
      ST_WORD_WAIT: begin
        if (press_s)                                   state_nxt_s = ST_MARK;
        else if (unit_tick_s && (unit_eff_s >= WORD_U)) state_nxt_s = ST_IDLE;
        else                                           state_nxt_s = ST_WORD_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Symbol emission decoded from the current state and this cycle's events.
  always_comb begin
    emit_s     = 1'b0;
    emit_sym_s = DOT;
    case (state_r)
      ST_MARK: begin
        if (release_s && !glitch_s) begin
          emit_s     = 1'b1;
          emit_sym_s = (unit_eff_s >= DASH_U) ? DASH : DOT;
        end else begin
          emit_s     = 1'b0;
        end
      end
      ST_SPACE: begin
        if (!press_s && unit_tick_s && (unit_eff_s >= LETTER_U)) begin
          emit_s     = 1'b1;
          emit_sym_s = LETTER_END;
        end else begin
          emit_s     = 1'b0;
        end
      end
      ST_WORD_WAIT: begin
        if (!press_s && unit_tick_s && (unit_eff_s >= WORD_U)) begin
          emit_s     = 1'b1;
          emit_sym_s = WORD_END;
        end else begin
          emit_s     = 1'b0;
        end
      end
      default: emit_s = 1'b0;
    endcase
  end

  // Output holding register; a symbol that cannot load is dropped and flagged sticky.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sym_valid_r <= 1'b0;
      sym_r       <= DOT;
      overflow_r  <= 1'b0;
    end else if (emit_s) begin
      if (!sym_valid_r || sym_ready_i) begin
        sym_valid_r <= 1'b1;
        sym_r       <= emit_sym_s;
      end else begin
        overflow_r  <= 1'b1;
      end
    end else if (sym_valid_r && sym_ready_i) begin
      sym_valid_r <= 1'b0;
    end
  end

  assign sym_valid_o = sym_valid_r;
  assign sym_o       = sym_r;
  assign overflow_o  = overflow_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Bench for morse_keyer_ctrl (UNIT_TICKS=4): directed and random key waveforms vs an interval model.
module tb_morse_keyer_ctrl;

  localparam int UT = 4, DASH_N = 2, LETTER_N = 2, WORD_N = 5, GLITCH = 16;
`ifdef MORSE_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif
  localparam int MAXT = 400;
  localparam int S_DOT = 0, S_DASH = 1, S_LE = 2, S_WE = 3;

  logic clk = 1'b0, resetn = 1'b0, key_i = 1'b0, sym_ready_i = 1'b1;
  logic sym_valid_o, overflow_o, busy_o;
  logic [1:0] sym_o;

  int total = 0, bad = 0;

  bit key_w [MAXT], rdy_w [MAXT], rst_w [MAXT];
  logic ov [MAXT], oo [MAXT], ob [MAXT];
  logic [1:0] os [MAXT];
  logic ev [MAXT], eo [MAXT], eb [MAXT];
  logic [1:0] es [MAXT];

  morse_keyer_ctrl #(.UNIT_TICKS(UT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_i       (key_i),
    .sym_valid_o (sym_valid_o),
    .sym_o       (sym_o),
    .sym_ready_i (sym_ready_i),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic clear_wave();
    for (int t = 0; t < MAXT; t++) begin
      key_w[t] = 1'b0; rdy_w[t] = 1'b1; rst_w[t] = 1'b0;
    end
  endtask

  task automatic set_key(input int from, input int to_excl);
    for (int t = from; t < to_excl; t++) key_w[t] = 1'b1;
  endtask

  // Expected outputs from interval lengths: marks classified on release, gaps timed from release.
  task automatic build_model(input int n);
    int mode, pre_mode, edge_t, em, nlen;
    bit prev, v, o;
    logic [1:0] s;
    mode = 0; pre_mode = 0; edge_t = 0; prev = 1'b0; v = 1'b0; o = 1'b0; s = 2'd0;
    for (int t = 0; t < n; t++) begin
      em = -1;
      if (rst_w[t]) begin
        mode = 0; prev = 1'b0; v = 1'b0; o = 1'b0; s = 2'd0;
      end else begin
        if (key_w[t] && !prev) begin
          pre_mode = mode; mode = 1; edge_t = t;
        end else if (!key_w[t] && prev) begin
          nlen = t - edge_t; edge_t = t;
          if (GLITCH_EN && nlen < GLITCH) mode = pre_mode;
          else begin
            em = (nlen / UT >= DASH_N) ? S_DASH : S_DOT; mode = 2;
          end
        end else if (mode == 2 && t - edge_t == LETTER_N * UT) begin
          em = S_LE; mode = 3;
        end else if (mode == 3 && t - edge_t == WORD_N * UT) begin
          em = S_WE; mode = 0;
        end
        if (em >= 0) begin
          if (!v || rdy_w[t]) begin v = 1'b1; s = 2'(em); end
          else o = 1'b1;
        end else if (v && rdy_w[t]) begin
          v = 1'b0;
        end
        prev = key_w[t];
      end
      ev[t] = v; es[t] = s; eo[t] = o; eb[t] = (mode != 0);
    end
  endtask

  // Reset, then play the waveform one cycle at a time and record the outputs after each edge.
  task automatic run_wave(input int n);
    @(negedge clk);
    resetn = 1'b0; key_i = 1'b0; sym_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      key_i = key_w[t]; sym_ready_i = rdy_w[t]; resetn = !rst_w[t];
      @(posedge clk);
      #1;
      ov[t] = sym_valid_o; os[t] = sym_o; oo[t] = overflow_o; ob[t] = busy_o;
    end
    build_model(n);
  endtask

  function automatic int count_sym(input int n, input int code);
    int c = 0;
    for (int t = 0; t < n; t++) if (ov[t] === 1'b1 && os[t] === 2'(code)) c++;
    return c;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; key_i = 1'b1; sym_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sym_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", sym_valid_o); end
    total++; if (sym_o !== 2'd0) begin bad++; $display("FAIL reset_sym got %0d want 0", sym_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    key_i = 1'b0;
  endtask

  task automatic test_dot();
    clear_wave(); set_key(2, 6); run_wave(40);
    for (int t = 0; t < 40; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL dot t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (ov[6] !== 1'b1 || os[6] !== 2'd0) begin bad++; $display("FAIL dot_latency got v=%b s=%0d want v=1 s=0", ov[6], os[6]); end
    total++; if (count_sym(40, S_DOT) != 1) begin bad++; $display("FAIL dot_once got %0d want 1", count_sym(40, S_DOT)); end
  endtask

  task automatic test_dash();
    clear_wave(); set_key(2, 10); run_wave(30);
    for (int t = 0; t < 30; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL dash t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (ov[10] !== 1'b1 || os[10] !== 2'd1) begin bad++; $display("FAIL dash_sym got v=%b s=%0d want v=1 s=1", ov[10], os[10]); end
  endtask

  task automatic test_letter_word();
    clear_wave(); set_key(2, 6); run_wave(40);
    for (int t = 0; t < 40; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL letter_word t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (ov[14] !== 1'b1 || os[14] !== 2'd2) begin bad++; $display("FAIL letter_end got v=%b s=%0d want v=1 s=2", ov[14], os[14]); end
    total++; if (ov[26] !== 1'b1 || os[26] !== 2'd3) begin bad++; $display("FAIL word_end got v=%b s=%0d want v=1 s=3", ov[26], os[26]); end
    total++; if (ob[25] !== 1'b1 || ob[26] !== 1'b0) begin bad++; $display("FAIL idle_busy got %b%b want 10", ob[25], ob[26]); end
  endtask

  task automatic test_cancel();
    clear_wave(); set_key(2, 6); set_key(11, 15); run_wave(60);
    for (int t = 0; t < 60; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL cancel t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (count_sym(60, S_LE) != 1) begin bad++; $display("FAIL cancel_letter got %0d want 1", count_sym(60, S_LE)); end
    total++; if (count_sym(60, S_DOT) != 2) begin bad++; $display("FAIL cancel_dots got %0d want 2", count_sym(60, S_DOT)); end
  endtask

  task automatic test_overflow();
    clear_wave();
    for (int t = 0; t < 40; t++) rdy_w[t] = 1'b0;
    set_key(2, 6); set_key(9, 13); run_wave(40);
    for (int t = 0; t < 40; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL overflow t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (oo[12] !== 1'b0 || oo[13] !== 1'b1) begin bad++; $display("FAIL ovf_set got %b%b want 01", oo[12], oo[13]); end
    total++; if (ov[39] !== 1'b1 || os[39] !== 2'd0 || oo[39] !== 1'b1) begin bad++; $display("FAIL ovf_hold got v=%b s=%0d o=%b want 1/0/1", ov[39], os[39], oo[39]); end
  endtask

  task automatic test_reset_mid_mark();
    clear_wave(); set_key(2, 8);
    for (int t = 5; t < 9; t++) rst_w[t] = 1'b1;
    run_wave(40);
    for (int t = 0; t < 40; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL reset_mid t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (count_sym(40, S_DOT) + count_sym(40, S_DASH) != 0) begin bad++; $display("FAIL reset_mid_sym got symbols want none"); end
  endtask

`ifdef MORSE_GLITCH_FILTER_EN
  task automatic test_glitch();
    clear_wave(); set_key(2, 12); set_key(40, 60); run_wave(80);
    for (int t = 0; t < 80; t++) begin
      total++;
      if ({ov[t], os[t], oo[t], ob[t]} !== {ev[t], es[t], eo[t], eb[t]}) begin
        bad++; $display("FAIL glitch t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", t, ov[t], os[t], oo[t], ob[t], ev[t], es[t], eo[t], eb[t]);
      end
    end
    total++; if (ov[12] !== 1'b0) begin bad++; $display("FAIL glitch_drop got %b want 0", ov[12]); end
    total++; if (ov[60] !== 1'b1 || os[60] !== 2'd1) begin bad++; $display("FAIL glitch_dash got v=%b s=%0d want 1/1", ov[60], os[60]); end
  endtask
`endif

  task automatic test_random();
    int t, len;
    bit lvl;
    for (int it = 0; it < 4; it++) begin
      clear_wave();
      t = 0; lvl = 1'b0;
      while (t < 300) begin
        len = lvl ? $urandom_range(1, 26) : $urandom_range(1, 30);
        for (int k = 0; k < len && t < 300; k++) begin
          key_w[t] = lvl;
          rdy_w[t] = ($urandom_range(0, 3) != 0);
          rst_w[t] = ($urandom_range(0, 249) == 0);
          t++;
        end
        lvl = !lvl;
      end
      run_wave(300);
      for (int c = 0; c < 300; c++) begin
        total++;
        if ({ov[c], os[c], oo[c], ob[c]} !== {ev[c], es[c], eo[c], eb[c]}) begin
          bad++; $display("FAIL random it=%0d t=%0d got v/s/o/b=%b/%0d/%b/%b want %b/%0d/%b/%b", it, c, ov[c], os[c], oo[c], ob[c], ev[c], es[c], eo[c], eb[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_dash();
    test_letter_word();
    test_cancel();
    test_overflow();
    test_reset_mid_mark();
`ifdef MORSE_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
